// File: rtl/fwd_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_ctrl_unit_pkg
// Purpose  : Shared select encodings and the producer-slot type for the
//            forwarding control stage.
// Revision : 1.0 - initial release
// ============================================================================
package fwd_ctrl_unit_pkg;

    // Operand mux select encodings
    localparam logic [1:0] c_FWD_NONE  = 2'b00;
    localparam logic [1:0] c_FWD_EXMEM = 2'b01;
    localparam logic [1:0] c_FWD_MEMWB = 2'b10;
    localparam logic [1:0] c_FWD_DMEM  = 2'b11;

    // Register address field width inside a slot; top-level REG_AW must not exceed it
    localparam int c_RD_MAX = 8;

    // Destination info of one in-flight instruction
    typedef struct packed {
        logic                valid;
        logic [c_RD_MAX-1:0] rd;
        logic                regwrite;
        logic                isload;
        logic                isjump;
    } slot_t;

    // Empty pipeline slot
    localparam slot_t c_BUBBLE = '{valid: 1'b0, rd: '0, regwrite: 1'b0,
                                   isload: 1'b0, isjump: 1'b0};

endpackage : fwd_ctrl_unit_pkg
`default_nettype wire

// File: rtl/fwd_ctrl_unit_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel
// Purpose  : Per-operand forwarding priority selector. The producer now in
//            EX (newest) wins over the one in MEM; a load in EX is served
//            from the data-memory read port instead of stalling.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel
    import fwd_ctrl_unit_pkg::*;
(
    input  logic [c_RD_MAX-1:0] i_r,
    input  logic                i_use,
    input  slot_t               i_ex,
    input  slot_t               i_mem,
    output logic [1:0]          o_fwd,
    output logic                o_jmp
);

    logic w_ex_hit;
    logic w_mem_hit;

    // x0 is hard-wired zero, so it never matches a producer
    assign w_ex_hit  = i_use && (i_r != '0) && i_ex.valid  && i_ex.regwrite  && (i_ex.rd  == i_r);
    assign w_mem_hit = i_use && (i_r != '0) && i_mem.valid && i_mem.regwrite && (i_mem.rd == i_r);

    // Priority: EX load, EX non-load, MEM, none
    always_comb begin
        o_fwd = c_FWD_NONE;
        o_jmp = 1'b0;
        if (w_ex_hit) begin
            if (i_ex.isload) begin
                o_fwd = c_FWD_DMEM;
            end else begin
                o_fwd = c_FWD_EXMEM;
                o_jmp = i_ex.isjump;
            end
        end else if (w_mem_hit) begin
            o_fwd = c_FWD_MEMWB;
        end
    end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/fwd_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_ctrl_unit
// Purpose  : Forwarding control stage. Shadows EX/MEM/WB destination info and
//            registers the A/B operand-mux selects for the instruction
//            entering EX, plus a count of non-zero selects issued.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_ctrl_unit
    import fwd_ctrl_unit_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic              ID_USE_RS1,
    input  logic              ID_USE_RS2,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              ID_REGWRITE,
    input  logic              ID_ISLOAD,
    input  logic              ID_ISJUMP,
    output logic [1:0]        FWD_A,
    output logic [1:0]        FWD_B,
    output logic              JMP_A,
    output logic              JMP_B,
    output logic [CNT_W-1:0]  FWD_CNT
);

    slot_t             r_ex;
    slot_t             r_mem;
    slot_t             r_wb;
    logic [1:0]        r_fwd_a;
    logic [1:0]        r_fwd_b;
    logic              r_jmp_a;
    logic              r_jmp_b;
    logic [CNT_W-1:0]  r_cnt;

    slot_t             w_id_slot;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;
    logic              w_jmp_a;
    logic              w_jmp_b;
    logic [CNT_W-1:0]  w_cnt_inc;

    // Incoming producer description for the instruction leaving ID
    assign w_id_slot = '{valid: 1'b1, rd: c_RD_MAX'(ID_RD), regwrite: ID_REGWRITE,
                         isload: ID_ISLOAD, isjump: ID_ISJUMP};

    fwd_sel u_sel_a (
        .i_r   (c_RD_MAX'(ID_RS1)),
        .i_use (ID_USE_RS1),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_fwd (w_fwd_a),
        .o_jmp (w_jmp_a)
    );

    fwd_sel u_sel_b (
        .i_r   (c_RD_MAX'(ID_RS2)),
        .i_use (ID_USE_RS2),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_fwd (w_fwd_b),
        .o_jmp (w_jmp_b)
    );

    // Number of operands that will actually be forwarded this advance
    assign w_cnt_inc = CNT_W'(w_fwd_a != c_FWD_NONE) + CNT_W'(w_fwd_b != c_FWD_NONE);

    // Slot shift and registered selects; reset beats flush, flush beats stall
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ex    <= c_BUBBLE;
            r_mem   <= c_BUBBLE;
            r_wb    <= c_BUBBLE;
            r_fwd_a <= c_FWD_NONE;
            r_fwd_b <= c_FWD_NONE;
            r_jmp_a <= 1'b0;
            r_jmp_b <= 1'b0;
            r_cnt   <= '0;
        end else if (FLUSH) begin
            r_wb    <= r_mem;
            r_mem   <= r_ex;
            r_ex    <= c_BUBBLE;
            r_fwd_a <= c_FWD_NONE;
            r_fwd_b <= c_FWD_NONE;
            r_jmp_a <= 1'b0;
            r_jmp_b <= 1'b0;
        end else if (!STALL) begin
            r_wb    <= r_mem;
            r_mem   <= r_ex;
            r_ex    <= w_id_slot;
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
            r_jmp_a <= w_jmp_a;
            r_jmp_b <= w_jmp_b;
            r_cnt   <= r_cnt + w_cnt_inc;
        end
    end

    assign FWD_A   = r_fwd_a;
    assign FWD_B   = r_fwd_b;
    assign JMP_A   = r_jmp_a;
    assign JMP_B   = r_jmp_b;
    assign FWD_CNT = r_cnt;

endmodule : fwd_ctrl_unit
`default_nettype wire

// File: tb/tb_fwd_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_ctrl_unit
// Purpose  : Scoreboard bench for fwd_ctrl_unit. A 16-bit and a 2-bit counter
//            instance share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst, stall, flush;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, regwrite, isload, isjump;

    logic [1:0]  fwd_a, fwd_b, fwd_a_w, fwd_b_w;
    logic        jmp_a, jmp_b, jmp_a_w, jmp_b_w;
    logic [15:0] cnt;
    logic [1:0]  cnt_w;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        ja;
        logic        jb;
        logic [15:0] cnt;
        logic [1:0]  cnt_w;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state: index 0 = EX, 1 = MEM, 2 = WB
    logic       m_v[3], m_rw[3], m_ld[3], m_jp[3];
    logic [4:0] m_rd[3];
    logic [1:0] m_fa, m_fb;
    logic       m_ja, m_jb;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    fwd_ctrl_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .STALL(stall), .FLUSH(flush),
        .ID_RS1(rs1), .ID_RS2(rs2), .ID_USE_RS1(use1), .ID_USE_RS2(use2),
        .ID_RD(rd), .ID_REGWRITE(regwrite), .ID_ISLOAD(isload), .ID_ISJUMP(isjump),
        .FWD_A(fwd_a), .FWD_B(fwd_b), .JMP_A(jmp_a), .JMP_B(jmp_b), .FWD_CNT(cnt)
    );

    fwd_ctrl_unit #(.REG_AW(5), .CNT_W(2)) dut_w (
        .CLK(clk), .RST(rst), .STALL(stall), .FLUSH(flush),
        .ID_RS1(rs1), .ID_RS2(rs2), .ID_USE_RS1(use1), .ID_USE_RS2(use2),
        .ID_RD(rd), .ID_REGWRITE(regwrite), .ID_ISLOAD(isload), .ID_ISJUMP(isjump),
        .FWD_A(fwd_a_w), .FWD_B(fwd_b_w), .JMP_A(jmp_a_w), .JMP_B(jmp_b_w), .FWD_CNT(cnt_w)
    );

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Spec select rule for one operand: {fwd[1:0], jmp}
    function automatic logic [2:0] msel(input logic [4:0] r, input logic u);
        logic ex_hit, mem_hit;
        ex_hit  = u && (r != 5'd0) && m_v[0] && m_rw[0] && (m_rd[0] == r);
        mem_hit = u && (r != 5'd0) && m_v[1] && m_rw[1] && (m_rd[1] == r);
        if (ex_hit)       return m_ld[0] ? 3'b110 : {2'b01, m_jp[0]};
        else if (mem_hit) return 3'b100;
        else              return 3'b000;
    endfunction

    // Update the model for the coming edge and push the expected outputs
    task automatic model_edge();
        logic [2:0] sa, sb;
        exp_t e;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_v[i] = 0; m_rw[i] = 0; m_ld[i] = 0; m_jp[i] = 0; m_rd[i] = 0;
            end
            m_fa = 0; m_fb = 0; m_ja = 0; m_jb = 0; m_cnt = 0;
        end else if (flush || !stall) begin
            sa = msel(rs1, use1);
            sb = msel(rs2, use2);
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_rw[i] = m_rw[i-1]; m_ld[i] = m_ld[i-1];
                m_jp[i] = m_jp[i-1]; m_rd[i] = m_rd[i-1];
            end
            if (flush) begin
                m_v[0] = 0; m_rw[0] = 0; m_ld[0] = 0; m_jp[0] = 0; m_rd[0] = 0;
                m_fa = 0; m_fb = 0; m_ja = 0; m_jb = 0;
            end else begin
                m_v[0] = 1; m_rw[0] = regwrite; m_ld[0] = isload; m_jp[0] = isjump; m_rd[0] = rd;
                m_fa = sa[2:1]; m_ja = sa[0];
                m_fb = sb[2:1]; m_jb = sb[0];
                m_cnt = m_cnt + (sa[2:1] != 0 ? 1 : 0) + (sb[2:1] != 0 ? 1 : 0);
            end
        end
        e.fa = m_fa; e.fb = m_fb; e.ja = m_ja; e.jb = m_jb;
        e.cnt = m_cnt[15:0]; e.cnt_w = m_cnt[1:0];
        sb_q.push_back(e);
    endtask

    // One clock: drive at negedge, model, sample 1 time unit after posedge
    task automatic step(input logic r, input logic s, input logic f,
                        input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
                        input logic [4:0] d, input logic rw, input logic ld, input logic jp,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f;
        rs1 = a1; use1 = u1; rs2 = a2; use2 = u2;
        rd = d; regwrite = rw; isload = ld; isjump = jp;
        model_edge();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_fwd_a"}, 32'(fwd_a), 32'(e.fa));
            check({tag, "_fwd_b"}, 32'(fwd_b), 32'(e.fb));
            check({tag, "_jmp_a"}, 32'(jmp_a), 32'(e.ja));
            check({tag, "_jmp_b"}, 32'(jmp_b), 32'(e.jb));
            check({tag, "_cnt"},   32'(cnt),   32'(e.cnt));
            check({tag, "_cnt_w"}, 32'(cnt_w), 32'(e.cnt_w));
            check({tag, "_w_fwd"}, 32'({fwd_a_w, fwd_b_w, jmp_a_w, jmp_b_w}),
                  32'({e.fa, e.fb, e.ja, e.jb}));
        end
    endtask

    // Shorthand for plain advances
    task automatic instr(input logic [4:0] d, input logic rw, input logic ld, input logic jp,
                         input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
                         input string tag);
        step(0, 0, 0, a1, u1, a2, u2, d, rw, ld, jp, tag);
    endtask

    task automatic nop(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic do_reset(input string tag);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0;
        regwrite = 0; isload = 0; isjump = 0;

        // Reset, with stall and flush asserted to show reset wins
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        do_reset("reset2");
        check("reset_fwd_a_zero", 32'(fwd_a), 32'd0);
        check("reset_cnt_zero", 32'(cnt), 32'd0);

        // Back-to-back ALU dependency
        instr(5, 1, 0, 0, 0, 0, 0, 0, "b2b_prod");
        instr(0, 0, 0, 0, 5, 1, 0, 0, "b2b_cons");
        check("b2b_fwd_a_01", 32'(fwd_a), 32'd1);
        check("b2b_cnt_1", 32'(cnt), 32'd1);

        // Distance-2 forwarding from MEM/WB
        instr(7, 1, 0, 0, 0, 0, 0, 0, "d2_prod");
        nop("d2_gap");
        instr(0, 0, 0, 0, 0, 0, 7, 1, "d2_cons");
        check("d2_fwd_b_10", 32'(fwd_b), 32'd2);

        // Load at distance 1 resolved from data memory
        instr(7, 1, 1, 0, 0, 0, 0, 0, "ld_prod");
        instr(0, 0, 0, 0, 0, 0, 7, 1, "ld_cons");
        check("ld_fwd_b_11", 32'(fwd_b), 32'd3);

        // Jump producer feeding both operands
        instr(1, 1, 0, 1, 0, 0, 0, 0, "jal_prod");
        instr(0, 0, 0, 0, 1, 1, 1, 1, "jal_cons");
        check("jal_jmp_ab", 32'({jmp_a, jmp_b}), 32'd3);

        // x0 destination never forwards
        instr(0, 1, 0, 1, 0, 0, 0, 0, "x0_prod");
        instr(0, 0, 0, 0, 0, 1, 0, 1, "x0_cons");

        // Newest producer wins
        instr(3, 1, 0, 0, 0, 0, 0, 0, "pri_old");
        instr(3, 1, 0, 0, 0, 0, 0, 0, "pri_new");
        instr(0, 0, 0, 0, 3, 1, 0, 0, "pri_cons");
        check("pri_fwd_a_01", 32'(fwd_a), 32'd1);

        // Stall for three cycles mid-sequence with a would-be consumer on ID
        instr(9, 1, 0, 0, 0, 0, 0, 0, "st_prod");
        instr(0, 0, 0, 0, 9, 1, 0, 0, "st_cons");
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, 0, 9, 1, 9, 1, 0, 0, "stall");
        instr(0, 0, 0, 0, 0, 0, 9, 1, "st_after");

        // Flush with stall: the flushed producer must not forward
        instr(12, 1, 0, 0, 0, 0, 0, 0, "fl_pre");
        step(0, 1, 1, 12, 1, 12, 1, 13, 1, 0, 0, "flush");
        instr(0, 0, 0, 0, 13, 1, 13, 1, "fl_cons");
        check("fl_cons_none", 32'({fwd_a, fwd_b}), 32'd0);

        // Reset mid-stream discards producers
        instr(14, 1, 0, 0, 0, 0, 0, 0, "rs_prod1");
        instr(15, 1, 0, 0, 0, 0, 0, 0, "rs_prod2");
        do_reset("rs_mid");
        instr(0, 0, 0, 0, 15, 1, 14, 1, "rs_cons");

        // Counter wrap on the 2-bit instance: five single forwards
        do_reset("wrap_rst");
        instr(4, 1, 0, 0, 0, 0, 0, 0, "wrap_p");
        for (int i = 0; i < 5; i++)
            instr(4, 1, 0, 0, 4, 1, 0, 0, "wrap");
        check("wrap_cnt_w_1", 32'(cnt_w), 32'd1);
        check("wrap_cnt_5", 32'(cnt), 32'd5);

        // Random traffic over a small register range
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0),
                 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fwd_ctrl_unit
`default_nettype wire
